icache_refill_unit: RTL and testbench

//  Direct-mapped instruction cache between the Fetch stage and backing instruction memory.

---
 rtl/icache_refill_unit.sv | 117 +++++++++++
 tb/tb_icache_refill_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_unit.sv
// Direct-mapped instruction cache with a combinational lookup port for Fetch
// and a line-refill FSM that pulls one 32-bit word per beat from instruction memory.
module icache_refill_unit #(
  parameter int ADDR_W         = 64,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              fetch_req,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              hit,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF - IDX;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state_q;
  logic [OFF-1:0]      beat_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_req_q;
  logic                flush_pend_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [31:0]         data_q [NUM_LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]    tag_q  [NUM_LINES];

  logic [OFF-1:0]   pc_word;
  logic [IDX-1:0]   pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX-1:0]   ref_idx;
  logic [TAG_W-1:0] ref_tag;
  logic             last_beat;
  logic             beat_done;
  logic             unused_pc_lsbs;

  assign pc_word        = pc_in[2 +: OFF];
  assign pc_idx         = pc_in[2+OFF +: IDX];
  assign pc_tag         = pc_in[ADDR_W-1 -: TAG_W];
  assign unused_pc_lsbs = ^pc_in[1:0];

  // The beat address only advances inside the line offset, so index and tag
  // of the line being refilled can be taken straight from mem_addr_q.
  assign ref_idx   = mem_addr_q[2+OFF +: IDX];
  assign ref_tag   = mem_addr_q[ADDR_W-1 -: TAG_W];
  assign last_beat = (beat_q == OFF'(WORDS_PER_LINE - 1));
  assign beat_done = (state_q == REFILL) && mem_ready;

  assign hit = fetch_req && (state_q == IDLE) && !flush &&
               valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign instruction = hit ? data_q[pc_idx][pc_word] : 32'h0;
  assign stall       = fetch_req && !hit;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (fetch_req && !hit) begin
            state_q      <= REFILL;
            beat_q       <= '0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {pc_in[ADDR_W-1:2+OFF], {(OFF+2){1'b0}}};
            flush_pend_q <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_ready) begin
            if (last_beat) begin
              // A flush seen at any point of the burst wins over the new line.
              if (flush_pend_q || flush) valid_q <= '0;
              else                      valid_q[ref_idx] <= 1'b1;
              state_q      <= IDLE;
              beat_q       <= '0;
              mem_req_q    <= 1'b0;
              mem_addr_q   <= '0;
              flush_pend_q <= 1'b0;
            end else begin
              beat_q     <= beat_q + OFF'(1);
              mem_addr_q <= mem_addr_q + ADDR_W'(4);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!reset && beat_done) begin
      data_q[ref_idx][beat_q] <= mem_rdata;
      if (last_beat) tag_q[ref_idx] <= ref_tag;
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: miss/refill, hits, slow memory,
// aliasing eviction, flush during refill and in idle, reset mid-refill.
module tb_icache_refill_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_in;
  logic        fetch_req;
  logic        flush;
  logic [31:0] instruction;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  icache_refill_unit #(.ADDR_W(64), .NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_req(fetch_req), .flush(flush),
    .instruction(instruction), .hit(hit), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents: generation byte, 0x5A, low 16 address bits.
  function automatic logic [31:0] mem_word(input logic [7:0] gen, input logic [63:0] a);
    return {gen, 8'h5A, a[15:0]};
  endfunction

  // Caller has set pc_in/fetch_req=1 at a negedge; services a full 4-beat refill.
  task automatic do_miss(input string tag, input logic [63:0] base, input int delay,
                         input logic [7:0] gen, input int flush_at, output int cnt);
    logic [63:0] a;
    cnt = 0;
    #1;
    check({tag, "_miss_hit"}, hit, 1'b0);
    check({tag, "_miss_stall"}, stall, 1'b1);
    check({tag, "_miss_req"}, mem_req, 1'b0);
    if (stall) cnt++;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      a = base + 64'(4 * b);
      for (int d = 0; d < delay; d++) begin
        mem_ready = 1'b0;
        #1;
        check({tag, "_wait_req"}, mem_req, 1'b1);
        check({tag, "_wait_addr"}, mem_addr, a);
        if (stall) cnt++;
        @(negedge clk);
      end
      mem_ready = 1'b1;
      mem_rdata = mem_word(gen, a);
      flush     = (b == flush_at);
      #1;
      check({tag, "_beat_req"}, mem_req, 1'b1);
      check({tag, "_beat_addr"}, mem_addr, a);
      check({tag, "_beat_hit"}, hit, 1'b0);
      if (stall) cnt++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    flush     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc_in = 64'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hit", hit, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_instr", instruction, 32'h0);
    @(negedge clk);

    // Test 1: cold miss at 0x1000, ready every cycle
    fetch_req = 1'b1; pc_in = 64'h1000;
    do_miss("t1", 64'h1000, 0, 8'h01, -1, stall_cnt);
    #1;
    check("t1_stall_cycles", 64'(stall_cnt), 64'd5);
    check("t1_hit", hit, 1'b1);
    check("t1_instr", instruction, 32'h015A1000);
    check("t1_stall", stall, 1'b0);
    check("t1_req", mem_req, 1'b0);
    @(negedge clk);

    // Test 2: same line, other word; stray mem_ready in idle is ignored
    pc_in = 64'h1008; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("t2_hit", hit, 1'b1);
    check("t2_instr", instruction, 32'h015A1008);
    check("t2_req", mem_req, 1'b0);
    @(negedge clk);
    pc_in = 64'h100C;
    #1;
    check("t2_req_next", mem_req, 1'b0);
    check("t2_instr_c", instruction, 32'h015A100C);
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Test 3: slow memory, 3 wait cycles per beat
    pc_in = 64'h2040;
    do_miss("t3", 64'h2040, 3, 8'h02, -1, stall_cnt);
    #1;
    check("t3_stall_cycles", 64'(stall_cnt), 64'd17);
    check("t3_instr", instruction, 32'h025A2040);
    @(negedge clk);
    pc_in = 64'h2044;
    #1;
    check("t3_instr_4", instruction, 32'h025A2044);
    @(negedge clk);
    pc_in = 64'h1004;
    #1;
    check("t3_other_line", instruction, 32'h015A1004);
    @(negedge clk);

    // Test 4: alias at same index evicts 0x1000
    pc_in = 64'h1100;
    do_miss("t4a", 64'h1100, 0, 8'h03, -1, stall_cnt);
    pc_in = 64'h110C;
    #1;
    check("t4_alias_instr", instruction, 32'h035A110C);
    @(negedge clk);
    pc_in = 64'h1000;
    do_miss("t4b", 64'h1000, 1, 8'h04, -1, stall_cnt);
    #1;
    check("t4_refetch_instr", instruction, 32'h045A1000);
    @(negedge clk);

    // Test 5: flush during beat 2 of a refill
    pc_in = 64'h3080;
    do_miss("t5", 64'h3080, 0, 8'h05, 2, stall_cnt);
    #1;
    check("t5_line_hit", hit, 1'b0);
    check("t5_line_stall", stall, 1'b1);
    fetch_req = 1'b0;
    @(negedge clk);
    fetch_req = 1'b1; pc_in = 64'h2040;
    #1;
    check("t5_old_line_hit", hit, 1'b0);
    fetch_req = 1'b0;
    @(negedge clk);

    // Flush in idle: hit forced low in the flush cycle, no refill started
    fetch_req = 1'b1; pc_in = 64'h3084;
    do_miss("t5b", 64'h3080, 0, 8'h06, -1, stall_cnt);
    #1;
    check("t5b_instr", instruction, 32'h065A3084);
    flush = 1'b1;
    #1;
    check("t5b_flush_hit", hit, 1'b0);
    @(negedge clk);
    flush = 1'b0; fetch_req = 1'b0;
    #1;
    check("t5b_no_refill", mem_req, 1'b0);
    fetch_req = 1'b1;
    #1;
    check("t5b_after_flush", hit, 1'b0);
    fetch_req = 1'b0;
    @(negedge clk);

    // Test 6: reset at beat 1 drops the refill
    fetch_req = 1'b1; pc_in = 64'h4000;
    #1;
    check("t6_miss", stall, 1'b1);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = mem_word(8'h07, 64'h4000);
    @(negedge clk);
    reset = 1'b1; mem_rdata = mem_word(8'h07, 64'h4004);
    #1;
    check("t6_beat1_addr", mem_addr, 64'h4004);
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; fetch_req = 1'b0;
    #1;
    check("t6_req", mem_req, 1'b0);
    check("t6_addr", mem_addr, 64'h0);
    check("t6_hit", hit, 1'b0);
    check("t6_stall", stall, 1'b0);
    @(negedge clk);
    fetch_req = 1'b1; pc_in = 64'h4008;
    do_miss("t6r", 64'h4000, 0, 8'h08, -1, stall_cnt);
    #1;
    check("t6_stall_cycles", 64'(stall_cnt), 64'd5);
    check("t6_instr", instruction, 32'h085A4008);
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
